// File: rtl/aes_128_decrypt_pkg.sv
// Shared AES definitions: round count, inverse S-box, GF(2^8) helpers
// and the FSM state encoding used by the iterative decryptor.
package aes_128_decrypt_pkg;

    localparam int NR_AES = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    // Row-major table: entry x lives at bits [2047-8x -: 8]
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[8 * (255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {
            mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)
        };
    endfunction

endpackage

// File: rtl/aes_128_decrypt_inv_round.sv
// One combinational inverse-cipher round:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
    import aes_128_decrypt_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] keyed;
    logic [127:0] mixed;

    // Byte (r,c) sits at index r+4c; row r rotates right by r
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int D = r + 4 * c;
            localparam int S = r + 4 * ((c - r + 4) % 4);
            assign keyed[127-8*D -: 8] =
                inv_sbox(state[127-8*S -: 8]) ^ round_key[127-8*D -: 8];
        end
        assign mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end

    assign next_state = last ? keyed : mixed;

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES inverse cipher, one round per clock, with
// valid/ready handshakes on both the ciphertext and plaintext sides.
module aes_128_decrypt
    import aes_128_decrypt_pkg::*;
#(
    parameter int NR = NR_AES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          ciphertext,
    input  logic [128*(NR+1)-1:0] expandedKey,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          plaintext
);

    localparam int CW = $clog2(NR + 1);

    fsm_e          fsm;
    logic [CW-1:0] cnt;
    logic [127:0]  data;
    logic [127:0]  rk;
    logic [127:0]  nxt;
    logic          last;

    assign rk        = expandedKey[128*int'(cnt) +: 128];
    assign last      = (cnt == '0);
    assign plaintext = data;

    aes_inv_round u_round (
        .state      (data),
        .round_key  (rk),
        .last       (last),
        .next_state (nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            data      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data     <= ciphertext ^ expandedKey[128*NR +: 128];
                        cnt      <= CW'(NR - 1);
                        in_ready <= 1'b0;
                        fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    data <= nxt;
                    if (last) begin
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Scoreboard bench for aes_128_decrypt: a forward AES model built from
// GF(2^8) arithmetic produces ciphertexts and the plaintexts to expect.
module tb_aes_128_decrypt;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  ciphertext = '0;
    logic [1407:0] ekey = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  plaintext;

    logic [7:0]   sbox [256];
    logic [127:0] cur_expect = '0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           acc_log [$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           rnd_ready = 1'b0;

    bit           busy = 1'b0;
    bit           held = 1'b0;
    bit           prev_valid = 1'b0;
    logic [127:0] held_pt = '0;

    aes_128_decrypt #(.NR(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ciphertext  (ciphertext),
        .expandedKey (ekey),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plaintext   (plaintext)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ek;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ek;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r] = s[r+4*c];
                    s[4*c]   = gmul(t[0], 2) ^ gmul(t[1], 3) ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ gmul(t[1], 2) ^ gmul(t[2], 3) ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ gmul(t[2], 2) ^ gmul(t[3], 3);
                    s[4*c+3] = gmul(t[0], 3) ^ t[1] ^ t[2] ^ gmul(t[3], 2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[128*rnd+127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            acc_q.delete();
            busy = 1'b0;
            held = 1'b0;
            prev_valid = 1'b0;
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || plaintext !== '0) begin
                n_bad++;
                $display("FAIL reset_values got rdy=%b vld=%b pt=%h want 1 0 0",
                         in_ready, out_valid, plaintext);
            end
        end else begin
            if (held) begin
                n_vec++;
                if (out_valid !== 1'b1 || plaintext !== held_pt) begin
                    n_bad++;
                    $display("FAIL hold got vld=%b pt=%h want 1 %h", out_valid, plaintext, held_pt);
                end
            end
            if (out_valid === 1'b1 && !prev_valid) begin
                n_vec++;
                if (acc_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_valid got out_valid=1 at cycle %0d want 0", cyc);
                end else begin
                    int a;
                    a = acc_q.pop_front();
                    if (cyc - a != 10) begin
                        n_bad++;
                        $display("FAIL latency got %0d want 10", cyc - a);
                    end
                end
            end
            if (busy) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_ready got in_ready=%b want 0", in_ready);
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(cur_expect);
                acc_q.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
                busy = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output got %h want none", plaintext);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (plaintext !== e) begin
                        n_bad++;
                        $display("FAIL plaintext got %h want %h", plaintext, e);
                    end
                end
                busy = 1'b0;
            end
            held = (out_valid === 1'b1) && !out_ready;
            held_pt = plaintext;
            prev_valid = (out_valid === 1'b1);
        end
    end

    task automatic send(input logic [127:0] ct, input logic [127:0] pt);
        int g;
        g = 0;
        ciphertext = ct;
        cur_expect = pt;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!(exp_q.size() == 0 && in_ready === 1'b1) && g < 200) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout got pending=%0d want 0", exp_q.size());
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic [127:0] pt2, ct2, key;
        int           n0, g;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ ((b << 1) | (b >> 7)) ^ ((b << 2) | (b >> 6))
                        ^ ((b << 3) | (b >> 5)) ^ ((b << 4) | (b >> 4)) ^ 8'h63;
        end
        ekey = expand(C1_KEY);

        // Known-answer block, offered on the first edge after reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        send(C1_CT, C1_PT);
        wait_done();

        // Backpressure with a competing request held on the input
        pt2 = rand128();
        ct2 = encrypt(pt2, ekey);
        out_ready = 1'b0;
        send(C1_CT, C1_PT);
        g = 0;
        while (out_valid !== 1'b1 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        ciphertext = ct2;
        cur_expect = pt2;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL backpressure got rdy=%b vld=%b want 0 1", in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        send(ct2, pt2);
        wait_done();

        // Back-to-back with in_valid held high
        n0 = acc_log.size();
        ciphertext = C1_CT;
        cur_expect = C1_PT;
        in_valid = 1'b1;
        g = 0;
        while (acc_log.size() < n0 + 2 && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc_log.size() < n0 + 2) begin
            n_bad++;
            $display("FAIL b2b_accepts got %0d want 2", acc_log.size() - n0);
        end else if (acc_log[n0+1] - acc_log[n0] != 12) begin
            n_bad++;
            $display("FAIL b2b_gap got %0d want 12", acc_log[n0+1] - acc_log[n0]);
        end
        wait_done();

        // Reset in the middle of a block
        send(C1_CT, C1_PT);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        send(C1_CT, C1_PT);
        wait_done();

        // Different ciphertext pulsed while busy must be ignored
        send(C1_CT, C1_PT);
        repeat (3) @(posedge clk);
        #1;
        pt2 = rand128();
        ciphertext = encrypt(pt2, ekey);
        cur_expect = pt2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();

        // Random round trips with random consumer stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            key = rand128();
            ekey = expand(key);
            pt2 = rand128();
            send(encrypt(pt2, ekey), pt2);
            wait_done();
        end
        rnd_ready = 1'b0;

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got %0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_128_decrypt.md
AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

Interface
REQ-001 SHALL have parameter NR, default NR_AES (10): number of cipher rounds.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: ciphertext is offered.
REQ-005 SHALL have port in_ready, output, 1: block can accept a ciphertext.
REQ-006 SHALL have port ciphertext, input, 128: input block; FIPS-197 state byte 0 at bits [127:120].
REQ-007 SHALL have port expandedKey, input, 128*(NR+1): round key i at [128*i +: 128], the same format the key-expansion block produces.
REQ-008 SHALL have port out_valid, output, 1: plaintext is valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the plaintext.
REQ-010 SHALL have port plaintext, output, 128: output block; same byte order as ciphertext.

Function
REQ-011 SHALL implement the FIPS-197 inverse cipher iteratively, one round per clock, using FSM states IDLE, ROUND and DONE.
REQ-012 SHALL assert in_ready only in IDLE; the input handshake is in_valid && in_ready at a rising edge.
REQ-013 On input handshake SHALL load state <= ciphertext ^ rk[NR], set round counter <= NR-1 and move to ROUND.
REQ-014 In ROUND SHALL apply, each cycle: InvShiftRows, InvSubBytes, AddRoundKey with rk[cnt], then InvMixColumns, except when cnt==0.
REQ-015 In ROUND SHALL decrement cnt each cycle; the cycle with cnt==0 moves to DONE.
REQ-016 SHALL assert out_valid exactly NR cycles after the input-handshake edge (10 for AES-128).
REQ-017 In DONE SHALL hold out_valid=1 and plaintext stable until out_valid && out_ready, then go to IDLE.
REQ-018 Minimum block period SHALL be NR+2 cycles (accept, NR rounds, output transfer).
REQ-019 SHALL ignore in_valid in ROUND and DONE; no input is captured and in_ready=0.
REQ-020 SHALL read expandedKey combinationally without registering it; the caller SHALL hold it stable from acceptance to out_valid.
REQ-021 plaintext SHALL be the state register; its value outside DONE is don't-care.
REQ-022 Round counter width SHALL be $clog2(NR+1); it SHALL NOT wrap below 0.

Reset
REQ-023 While rst=0, outputs SHALL be: FSM=IDLE, in_ready=1, out_valid=0, plaintext=0, cnt=0.
REQ-024 Reset asserted in ROUND or DONE SHALL discard the in-flight block immediately; no out_valid SHALL follow.
REQ-025 The first input handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-026 The shared AES package SHALL hold NR_AES, the inverse S-box table or function, the GF(2^8) xtime/multiply helpers, and the FSM state enum.
REQ-027 SHALL contain one combinational sub-module, aes_inv_round, with ports in state, round key, last-round flag and out state.
REQ-028 InvMixColumns SHALL use the fixed coefficients 0e/0b/0d/09 built from xtime chains, with no multiplier inference.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid at accept+10.
REQ-030 Backpressure: out_ready=0 for 5 cycles after out_valid -> plaintext and out_valid stable, in_ready=0, a new in_valid is not accepted.
REQ-031 Back-to-back: in_valid held high, out_ready=1, two C.1 blocks -> handshakes 12 cycles apart, both outputs correct.
REQ-032 Reset mid-operation: rst=0 at accept+4 for 1 cycle -> out_valid never rises for that block; the next C.1 block decrypts correctly.
REQ-033 Round trip: 100 random key/plaintext pairs through key expansion plus the AES_128 encryptor, then through this block -> output equals the original plaintext.
REQ-034 Busy input: in_valid pulsed with a different ciphertext during ROUND -> ignored; the output is the first block's plaintext.
